// File: rtl/case_stream_conv.sv
// case_stream_conv: LANES-wide ASCII case converter (pass/upper/lower/title) behind a
// valid/ready handshake, one register stage, plus a saturating count of modified bytes.
module case_stream_conv #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_last,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     conv_count
);

    localparam logic [1:0]       MODE_PASS  = 2'd0;
    localparam logic [1:0]       MODE_UPPER = 2'd1;
    localparam logic [1:0]       MODE_LOWER = 2'd2;
    localparam logic [1:0]       MODE_TITLE = 2'd3;
    localparam logic [CNT_W:0]   ONE        = 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_word_start;
    logic [8*LANES-1:0]   r_out_data;
    logic [CNT_W-1:0]     r_conv_count;

    logic                 w_accept;
    logic [LANES-1:0]     w_is_upper;
    logic [LANES-1:0]     w_is_lower;
    logic [LANES:0]       w_ws;
    logic [8*LANES-1:0]   w_conv_data;
    logic [CNT_W:0]       w_nchg;
    logic [CNT_W:0]       w_sum;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign conv_count = r_conv_count;

    // w_ws[i] is the word-start flag seen by lane i; w_ws[LANES] carries into the next beat.
    always_comb begin
        w_is_upper  = '0;
        w_is_lower  = '0;
        w_ws        = '0;
        w_conv_data = '0;
        w_nchg      = '0;
        w_ws[0]     = r_word_start;
        for (int i = 0; i < LANES; i++) begin
            w_is_upper[i] = (in_data[8*i +: 8] >= 8'h41) && (in_data[8*i +: 8] <= 8'h5A);
            w_is_lower[i] = (in_data[8*i +: 8] >= 8'h61) && (in_data[8*i +: 8] <= 8'h7A);
            w_conv_data[8*i +: 8] = in_data[8*i +: 8];
            case (mode)
                MODE_UPPER: begin
                    if (w_is_lower[i])
                        w_conv_data[8*i +: 8] = in_data[8*i +: 8] & 8'hDF;
                end
                MODE_LOWER: begin
                    if (w_is_upper[i])
                        w_conv_data[8*i +: 8] = in_data[8*i +: 8] | 8'h20;
                end
                MODE_TITLE: begin
                    if (w_ws[i] && w_is_lower[i])
                        w_conv_data[8*i +: 8] = in_data[8*i +: 8] & 8'hDF;
                    else if (!w_ws[i] && w_is_upper[i])
                        w_conv_data[8*i +: 8] = in_data[8*i +: 8] | 8'h20;
                end
                MODE_PASS: ;
                default: ;
            endcase
            w_ws[i+1] = !(w_is_upper[i] || w_is_lower[i]);
            if (w_conv_data[8*i +: 8] != in_data[8*i +: 8])
                w_nchg = w_nchg + ONE;
        end
    end

    assign w_sum = {1'b0, r_conv_count} + w_nchg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_conv_data;
            r_out_last  <= in_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Tracked in every mode so entering title mode mid-string picks up the right state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_word_start <= 1'b1;
        else if (w_accept)
            r_word_start <= in_last ? 1'b1 : w_ws[LANES];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_conv_count <= '0;
        else if (cnt_clr)
            r_conv_count <= '0;
        else if (w_accept)
            r_conv_count <= w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_case_stream_conv.sv
// Bench for case_stream_conv: directed scenarios plus randomized traffic, all checked
// every cycle against a character-level reference model and an expected-beat queue.
module tb_case_stream_conv;

    localparam int LANES = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic [31:0] out_data;
    logic [15:0] conv_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    case_stream_conv #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cnt_clr(cnt_clr), .conv_count(conv_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (character level) ----------------
    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    function automatic logic [7:0] conv_char(input logic [7:0] c, input logic [1:0] m, input bit ws);
        logic [7:0] r;
        bit up;
        bit lo;
        up = (c >= 8'h41 && c <= 8'h5A);
        lo = (c >= 8'h61 && c <= 8'h7A);
        r  = c;
        case (m)
            2'd1: if (lo) r = c - 8'd32;
            2'd2: if (up) r = c + 8'd32;
            2'd3: begin
                if (ws && lo)       r = c - 8'd32;
                else if (!ws && up) r = c + 8'd32;
            end
            default: r = c;
        endcase
        return r;
    endfunction

    function automatic void model_beat(input logic [31:0] d, input logic [1:0] m, input bit ws_in,
                                       output logic [31:0] o, output bit ws_out, output int nchg);
        bit ws;
        ws   = ws_in;
        nchg = 0;
        o    = '0;
        for (int i = 0; i < LANES; i++) begin
            o[8*i +: 8] = conv_char(d[8*i +: 8], m, ws);
            if (o[8*i +: 8] != d[8*i +: 8]) nchg++;
            ws = !is_letter(d[8*i +: 8]);
        end
        ws_out = ws;
    endfunction

    function automatic logic [31:0] str4(input string s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    logic [32:0] exp_q[$];
    bit          m_ws  = 1'b1;
    int          m_cnt = 0;
    logic [31:0] mon_o;
    bit          mon_ws;
    int          mon_n;

    // Compare first (outputs of the current cycle), then advance the model by what
    // the next rising edge will do with the inputs that are now stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ws  = 1'b1;
            m_cnt = 0;
            chk("reset_out_valid", out_valid, 0);
            chk("reset_out_data", out_data, 0);
            chk("reset_out_last", out_last, 0);
            chk("reset_conv_count", conv_count, 0);
        end else begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got out_data %h, expected no beat", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0][31:0]);
                    chk("out_last", out_last, exp_q[0][32]);
                end
            end else begin
                chk("idle_queue_depth", exp_q.size(), 0);
            end
            chk("conv_count", conv_count, m_cnt);
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                model_beat(in_data, mode, m_ws, mon_o, mon_ws, mon_n);
                exp_q.push_back({in_last, mon_o});
                m_ws = in_last ? 1'b1 : mon_ws;
                if (!cnt_clr) m_cnt = (m_cnt + mon_n > 65535) ? 65535 : m_cnt + mon_n;
            end
            if (cnt_clr) m_cnt = 0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [1:0] m, input bit last);
        int k;
        bit got;
        @(posedge clk); #1;
        in_data = d; mode = m; in_last = last; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < 50) begin
            @(negedge clk);
            got = in_ready;
            k++;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 3)       return 8'h41 + 8'($urandom_range(0, 25));
        else if (sel < 6)  return 8'h61 + 8'($urandom_range(0, 25));
        else if (sel == 6) return (($urandom % 2) == 0) ? 8'h20 : 8'h2E;
        else               return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] p_o;
    bit          p_ws;
    int          p_n;
    bit          acc;

    initial begin
        // model pins
        model_beat(32'h417A7B61, 2'd1, 1'b1, p_o, p_ws, p_n);
        chk("model_pin_upper", p_o, 32'h415A7B41);
        chk("model_pin_upper_n", p_n, 2);
        model_beat(str4("hELL"), 2'd3, 1'b1, p_o, p_ws, p_n);
        chk("model_pin_title", p_o, str4("Hell"));
        chk("model_pin_title_ws", p_ws, 0);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // 1: upper
        send_beat(32'h417A7B61, 2'd1, 1'b0);
        chk("t1_out", out_data, 32'h415A7B41);
        chk("t1_count", conv_count, 2);
        // 2: lower, high byte untouched
        send_beat(32'hEB472E48, 2'd2, 1'b1);
        chk("t2_out", out_data, 32'hEB672E68);
        chk("t2_count", conv_count, 4);
        // 3: title across beats
        send_beat(str4("hELL"), 2'd3, 1'b0);
        chk("t3_beat1", out_data, str4("Hell"));
        send_beat(str4("o wO"), 2'd3, 1'b0);
        chk("t3_beat2", out_data, str4("o Wo"));
        send_beat(str4("RLD!"), 2'd3, 1'b1);
        chk("t3_beat3", out_data, str4("rld!"));
        chk("t3_last", out_last, 1);
        send_beat(str4("abc "), 2'd3, 1'b0);
        chk("t3_after_last", out_data, str4("Abc "));

        // 4: backpressure
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd1; in_last = 1'b0; in_data = str4("abcd");
        @(posedge clk); #1;
        in_data = str4("wxyz");
        for (int k = 0; k < 3; k++) begin
            chk("t4_in_ready", in_ready, 0);
            chk("t4_hold", out_data, str4("ABCD"));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_release", out_data, str4("WXYZ"));
        chk("t4_release_valid", out_valid, 1);

        // 5: saturation and clear priority
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0; mode = 2'd1; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (16384) begin
            for (int i = 0; i < 4; i++) in_data[8*i +: 8] = 8'h61 + 8'($urandom_range(0, 25));
            @(posedge clk); #1;
        end
        chk("t5_saturated", conv_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stays", conv_count, 16'hFFFF);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0; in_valid = 1'b0;
        chk("t5_clear_with_accept", conv_count, 0);

        // 6: async reset mid-stream
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd3; in_last = 1'b0; in_data = str4("abcd");
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t6_held_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_data", out_data, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1; out_ready = 1'b1;
        send_beat(str4("xy z"), 2'd3, 1'b0);
        chk("t6_title_after_reset", out_data, str4("Xy Z"));

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                for (int i = 0; i < 4; i++) in_data[8*i +: 8] = rand_char();
                in_last  = ($urandom % 4) == 0;
                mode     = 2'($urandom_range(0, 3));
                in_valid = ($urandom % 4) != 0;
            end
            out_ready = ($urandom % 3) != 0;
            cnt_clr   = ($urandom % 40) == 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
